// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 flash read responder backed by a 32-bit word memory port
// Define SPI_FLASH_RESP_JEDEC_EN to decode 0x05 (status) and 0x9F (JEDEC ID) besides 0x03 (read).
`timescale 1ns/1ps
module spi_flash_responder #(
    parameter logic [23:0] JEDEC_ID   = 24'h012018,
    parameter logic [7:0]  STATUS_VAL = 8'h00
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        spi_cs_n,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    output logic        spi_miso,
    output logic        spi_miso_oe,
    output logic [21:0] mem_adr_o,
    output logic        mem_rd_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_dat_i,
    output logic        busy_o,
    output logic        err_o
);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, STAT, ID, IGNORE} state_t;

    state_t      state;
    logic [1:0]  cs_s, sck_s, mosi_s;
    logic        sck_d;
    logic [4:0]  bit_cnt;
    logic [2:0]  out_cnt;
    logic [1:0]  lane;
    logic [22:0] sr;
    logic [7:0]  tx;
    logic [31:0] buf_w, shd_w;
    logic        buf_vld, shd_vld, stale;
    logic [21:0] buf_wa;

    logic        sck_rise, sck_fall, ack, tx_phase, tx_load, promote;
    logic [7:0]  cmd_byte, buf_byte, load_byte;
    logic [23:0] addr_full;

    assign sck_rise  = sck_s[1] & ~sck_d;
    assign sck_fall  = ~sck_s[1] & sck_d;
    assign ack       = mem_ack_i & mem_rd_o;
    assign tx_phase  = (state == DATA) || (state == STAT) || (state == ID);
    assign tx_load   = sck_fall && tx_phase && (out_cnt == 3'd0);
    assign promote   = tx_load && (state == DATA) && (lane == 2'd3);
    assign cmd_byte  = {sr[6:0], mosi_s[1]};
    assign addr_full = {sr, mosi_s[1]};
    assign busy_o    = ~cs_s[1];

    always_comb begin
        case (lane)
            2'd0:    buf_byte = buf_w[31:24];
            2'd1:    buf_byte = buf_w[23:16];
            2'd2:    buf_byte = buf_w[15:8];
            default: buf_byte = buf_w[7:0];
        endcase
    end

    // A byte whose word has not arrived yet goes out as 0xFF (underrun).
    always_comb begin
        load_byte = 8'h00;
        case (state)
            DATA: load_byte = buf_vld ? buf_byte : 8'hFF;
            STAT: load_byte = STATUS_VAL;
            ID: begin
                case (lane)
                    2'd0:    load_byte = JEDEC_ID[23:16];
                    2'd1:    load_byte = JEDEC_ID[15:8];
                    2'd2:    load_byte = JEDEC_ID[7:0];
                    default: load_byte = 8'h00;
                endcase
            end
            default: load_byte = 8'h00;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            cs_s        <= 2'b11;
            sck_s       <= 2'b00;
            mosi_s      <= 2'b00;
            sck_d       <= 1'b0;
            bit_cnt     <= '0;
            out_cnt     <= '0;
            lane        <= '0;
            sr          <= '0;
            tx          <= '0;
            buf_w       <= '0;
            shd_w       <= '0;
            buf_vld     <= 1'b0;
            shd_vld     <= 1'b0;
            stale       <= 1'b0;
            buf_wa      <= '0;
            spi_miso    <= 1'b0;
            spi_miso_oe <= 1'b0;
            mem_adr_o   <= '0;
            mem_rd_o    <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            cs_s   <= {cs_s[0], spi_cs_n};
            sck_s  <= {sck_s[0], spi_sck};
            mosi_s <= {mosi_s[0], spi_mosi};
            sck_d  <= sck_s[1];
            err_o  <= 1'b0;
            if (sck_rise)
                sr <= {sr[21:0], mosi_s[1]};
            if (ack) begin
                mem_rd_o <= 1'b0;
                stale    <= 1'b0;
            end

            if (state != IDLE && cs_s[1]) begin
                // Abort: a fetch still in flight completes, but its data is dropped.
                state       <= IDLE;
                spi_miso_oe <= 1'b0;
                spi_miso    <= 1'b0;
                buf_vld     <= 1'b0;
                shd_vld     <= 1'b0;
                if (mem_rd_o && !mem_ack_i)
                    stale <= 1'b1;
            end else begin
                if (tx_load) begin
                    spi_miso_oe <= 1'b1;
                    spi_miso    <= load_byte[7];
                    tx          <= {load_byte[6:0], 1'b0};
                    out_cnt     <= 3'd1;
                    if (!(state == ID && lane == 2'd3))
                        lane <= lane + 2'd1;
                    if (state == DATA && !buf_vld)
                        err_o <= 1'b1;
                end else if (sck_fall && tx_phase) begin
                    spi_miso <= tx[7];
                    tx       <= {tx[6:0], 1'b0};
                    out_cnt  <= out_cnt + 3'd1;
                end

                case (state)
                    IDLE: begin
                        if (!cs_s[1]) begin
                            state   <= CMD;
                            bit_cnt <= '0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd7) begin
                                bit_cnt <= '0;
                                out_cnt <= '0;
                                lane    <= '0;
                                case (cmd_byte)
                                    8'h03: state <= ADDR;
`ifdef SPI_FLASH_RESP_JEDEC_EN
                                    8'h05: state <= STAT;
                                    8'h9F: state <= ID;
`endif
                                    default: begin
                                        state <= IGNORE;
                                        err_o <= 1'b1;
                                    end
                                endcase
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (bit_cnt == 5'd23) begin
                                state   <= DATA;
                                bit_cnt <= '0;
                                lane    <= addr_full[1:0];
                                buf_wa  <= addr_full[23:2];
                                buf_vld <= 1'b0;
                                shd_vld <= 1'b0;
                                if (!mem_rd_o || ack) begin
                                    mem_rd_o  <= 1'b1;
                                    mem_adr_o <= addr_full[23:2];
                                end
                            end
                        end
                    end
                    DATA: begin
                        if (promote) begin
                            buf_w   <= shd_w;
                            buf_vld <= shd_vld;
                            shd_vld <= 1'b0;
                            buf_wa  <= buf_wa + 22'd1;
                        end
                        // Returned words are steered by address so a late word never lands in the wrong slot.
                        if (ack && !stale) begin
                            if (mem_adr_o == buf_wa && !promote) begin
                                buf_w   <= mem_dat_i;
                                buf_vld <= 1'b1;
                            end else if (mem_adr_o == buf_wa + 22'd1) begin
                                if (promote) begin
                                    buf_w   <= mem_dat_i;
                                    buf_vld <= 1'b1;
                                end else begin
                                    shd_w   <= mem_dat_i;
                                    shd_vld <= 1'b1;
                                end
                            end
                        end else if (!mem_rd_o && !promote) begin
                            if (!buf_vld) begin
                                mem_rd_o  <= 1'b1;
                                mem_adr_o <= buf_wa;
                            end else if (!shd_vld) begin
                                mem_rd_o  <= 1'b1;
                                mem_adr_o <= buf_wa + 22'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - scoreboard bench for spi_flash_responder
`timescale 1ns/1ps
module tb_spi_flash_responder;
    localparam int H = 6;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        spi_cs_n = 1'b1;
    logic        spi_sck = 1'b0;
    logic        spi_mosi = 1'b0;
    logic        spi_miso, spi_miso_oe;
    logic [21:0] mem_adr_o;
    logic        mem_rd_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_dat_i = 32'h0;
    logic        busy_o, err_o;

    always #5 wb_clk_i = ~wb_clk_i;

    spi_flash_responder dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .spi_cs_n   (spi_cs_n),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .mem_adr_o  (mem_adr_o),
        .mem_rd_o   (mem_rd_o),
        .mem_ack_i  (mem_ack_i),
        .mem_dat_i  (mem_dat_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    int          n_cmp = 0;
    int          n_mis = 0;
    int          err_cnt = 0;
    int          err_base = 0;
    int          ack_delay = 2;
    logic        capture = 1'b0;
    logic        oe_seen = 1'b0;
    logic [7:0]  exp_bytes[$];
    logic [21:0] exp_fetch[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [21:0] a);
        case (a)
            22'h000001: return 32'hDEADBEEF;
            22'h000002: return 32'h01234567;
            22'h3FFFFF: return 32'h11223344;
            22'h000000: return 32'h55667788;
            default:    return 32'hA5A5A5A5;
        endcase
    endfunction

    // Memory model: acknowledge each request ack_delay cycles after it appears.
    initial begin
        logic [21:0] a;
        forever begin
            @(negedge wb_clk_i);
            if (mem_rd_o === 1'b1) begin
                a = mem_adr_o;
                repeat (ack_delay - 1) @(negedge wb_clk_i);
                mem_dat_i = mem_word(a);
                mem_ack_i = 1'b1;
                @(negedge wb_clk_i);
                mem_ack_i = 1'b0;
            end
        end
    end

    // Fetch monitor: each new request is compared with the next expected word address.
    initial begin
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge wb_clk_i);
            if (mem_rd_o === 1'b1 && !prev && exp_fetch.size() > 0)
                check("fetch_adr", {10'd0, mem_adr_o}, {10'd0, exp_fetch.pop_front()});
            prev = (mem_rd_o === 1'b1);
        end
    end

    // Byte monitor: deserialise miso on sck rises while capturing.
    initial begin
        int         cnt;
        logic [7:0] sh;
        logic       oe_ok;
        cnt = 0;
        sh = 8'h00;
        oe_ok = 1'b1;
        forever begin
            @(posedge spi_sck);
            if (!capture) begin
                cnt = 0;
                oe_ok = 1'b1;
            end else begin
                sh = {sh[6:0], spi_miso};
                oe_ok = oe_ok & (spi_miso_oe === 1'b1);
                cnt++;
                if (cnt == 8) begin
                    if (exp_bytes.size() == 0)
                        check("miso_extra_byte", {24'd0, sh}, 32'hFFFF_FFFF);
                    else
                        check("miso_byte", {23'd0, oe_ok, sh}, {23'd0, 1'b1, exp_bytes.pop_front()});
                    cnt = 0;
                    oe_ok = 1'b1;
                end
            end
        end
    end

    initial forever begin
        @(negedge wb_clk_i);
        if (err_o === 1'b1) err_cnt++;
        if (spi_miso_oe === 1'b1) oe_seen = 1'b1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge wb_clk_i);
    endtask

    task automatic spi_bit(input logic b);
        spi_mosi = b;
        tick(H);
        spi_sck = 1'b1;
        tick(H);
        spi_sck = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    task automatic cs_end();
        tick(H);
        spi_cs_n = 1'b1;
        tick(12);
    endtask

    task automatic read_start(input logic [23:0] a);
        spi_cs_n = 1'b0;
        tick(H);
        spi_byte(8'h03);
        spi_byte(a[23:16]);
        spi_byte(a[15:8]);
        spi_byte(a[7:0]);
    endtask

    task automatic read_bytes(input logic [23:0] a, input int n);
        read_start(a);
        capture = 1'b1;
        repeat (n) spi_byte(8'h00);
        capture = 1'b0;
        cs_end();
    endtask

    task automatic cmd_txn(input logic [7:0] c, input int n, input logic cap);
        oe_seen = 1'b0;
        spi_cs_n = 1'b0;
        tick(H);
        spi_byte(c);
        capture = cap;
        repeat (n) spi_byte(8'h00);
        capture = 1'b0;
        cs_end();
    endtask

    task automatic expect_done(input string tag, input int errs);
        check({tag, "_err_pulses"}, err_cnt - err_base, errs);
        check({tag, "_bytes_left"}, exp_bytes.size(), 0);
        check({tag, "_fetches_left"}, exp_fetch.size(), 0);
        exp_bytes.delete();
        exp_fetch.delete();
        err_base = err_cnt;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"}, {31'd0, spi_miso}, 0);
        check({tag, "_miso_oe"}, {31'd0, spi_miso_oe}, 0);
        check({tag, "_mem_rd"}, {31'd0, mem_rd_o}, 0);
        check({tag, "_mem_adr"}, {10'd0, mem_adr_o}, 0);
        check({tag, "_busy"}, {31'd0, busy_o}, 0);
        check({tag, "_err"}, {31'd0, err_o}, 0);
    endtask

    initial begin
        #500000;
        n_mis++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(3);
        check_reset_outputs("reset");
        wb_rst_i = 1'b0;
        tick(5);

        exp_fetch.push_back(22'h000001);
        exp_bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        read_bytes(24'h000004, 4);
        expect_done("aligned", 0);

        exp_fetch = '{22'h000001, 22'h000002};
        exp_bytes = '{8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        read_bytes(24'h000006, 6);
        expect_done("unaligned", 0);

        exp_fetch = '{22'h3FFFFF, 22'h000000};
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        read_bytes(24'hFFFFFC, 8);
        expect_done("wrap", 0);

        ack_delay = 40;
        exp_fetch.push_back(22'h000001);
        exp_bytes = '{8'hFF, 8'hAD};
        read_bytes(24'h000004, 2);
        tick(60);
        ack_delay = 2;
        expect_done("underrun", 1);

        read_start(24'h000004);
        repeat (4) spi_bit(1'b0);
        check("abort_oe_before", {31'd0, spi_miso_oe}, 1);
        check("abort_busy_before", {31'd0, busy_o}, 1);
        spi_cs_n = 1'b1;
        tick(3);
        check("abort_oe_after", {31'd0, spi_miso_oe}, 0);
        check("abort_busy_after", {31'd0, busy_o}, 0);
        tick(12);
        expect_done("abort", 0);

`ifdef SPI_FLASH_RESP_JEDEC_EN
        exp_bytes = '{8'h01, 8'h20, 8'h18, 8'h00};
        cmd_txn(8'h9F, 4, 1'b1);
        expect_done("jedec_id", 0);
        exp_bytes = '{8'h00, 8'h00};
        cmd_txn(8'h05, 2, 1'b1);
        expect_done("status", 0);
`else
        cmd_txn(8'h9F, 4, 1'b0);
        check("jedec_off_oe", {31'd0, oe_seen}, 0);
        expect_done("jedec_off", 1);
        cmd_txn(8'h05, 2, 1'b0);
        check("status_off_oe", {31'd0, oe_seen}, 0);
        expect_done("status_off", 1);
`endif
        cmd_txn(8'h0B, 2, 1'b0);
        check("cmd0b_oe", {31'd0, oe_seen}, 0);
        expect_done("cmd0b", 1);

        read_start(24'h000004);
        repeat (12) spi_bit(1'b0);
        wb_rst_i = 1'b1;
        #1;
        check_reset_outputs("midread_reset");
        tick(3);
        wb_rst_i = 1'b0;
        tick(3);
        spi_cs_n = 1'b1;
        tick(12);
        expect_done("midread_reset", 0);

        exp_fetch = '{22'h000001, 22'h000002};
        exp_bytes = '{8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
        read_bytes(24'h000006, 6);
        expect_done("after_reset", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
